// File: rtl/vend_pkg.sv
// Shared types for the vending-machine transaction sequencer: FSM states,
// coin-acceptor encodings and coin values in nickels.
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DISPENSE,
      CHANGE
   } vend_state_e;

   typedef enum logic [1:0] {
      COIN_NONE    = 2'b00,
      COIN_NICKEL  = 2'b01,
      COIN_DIME    = 2'b10,
      COIN_INVALID = 2'b11
   } coin_e;

   localparam logic [1:0] NICKEL_VALUE = 2'd1;
   localparam logic [1:0] DIME_VALUE   = 2'd2;

   // Invalid and idle codes are worth nothing; rejection is decided by the caller.
   function automatic logic [1:0] coin_value(input logic [1:0] coin);
      case (coin)
         COIN_NICKEL: return NICKEL_VALUE;
         COIN_DIME:   return DIME_VALUE;
         default:     return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/vend_if.sv
// Coin-acceptor, select-button and actuator handshake bundle for vend_controller.
// master = machine environment, slave = the controller.
interface vend_if #(
   parameter int NUM_SLOTS = 4,
   parameter int CREDIT_W  = 4
);
   localparam int SLOT_W = $clog2(NUM_SLOTS);

   logic [1:0]           coin;
   logic                 cancel;
   logic [NUM_SLOTS-1:0] sel_req;
   logic [NUM_SLOTS-1:0] slot_empty;
   logic                 disp_ack;
   logic                 chg_ack;
   logic [CREDIT_W-1:0]  credit;
   logic                 can_vend;
   logic                 disp_req;
   logic [SLOT_W-1:0]    disp_slot;
   logic                 chg_req;
   logic                 coin_reject;
   logic                 busy;
   logic                 fault;

   modport master (
      output coin, cancel, sel_req, slot_empty, disp_ack, chg_ack,
      input  credit, can_vend, disp_req, disp_slot, chg_req, coin_reject, busy, fault
   );

   modport slave (
      input  coin, cancel, sel_req, slot_empty, disp_ack, chg_ack,
      output credit, can_vend, disp_req, disp_slot, chg_req, coin_reject, busy, fault
   );

endinterface

// File: rtl/vend_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting slot at or after ptr,
// wrapping past the top slot. Purely combinational.
module vend_rr_arbiter #(
   parameter int NUM_SLOTS = 4
) (
   input  logic [NUM_SLOTS-1:0]         req,
   input  logic [$clog2(NUM_SLOTS)-1:0] ptr,
   output logic [NUM_SLOTS-1:0]         grant,
   output logic [$clog2(NUM_SLOTS)-1:0] grant_idx
);
   localparam int IDX_W = $clog2(NUM_SLOTS);

   int   slot;
   logic found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      slot      = 0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         slot = (int'(ptr) + i) % NUM_SLOTS;
         if (!found && req[slot]) begin
            found           = 1'b1;
            grant[slot]     = 1'b1;
            grant_idx       = IDX_W'(slot);
         end
      end
   end

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: coin credit, round-robin product select, one
// shared dispenser, nickel-at-a-time change. Optional feature: VEND_TIMEOUT_EN.
module vend_controller
   import vend_pkg::*;
#(
   parameter int NUM_SLOTS      = 4,
   parameter int PRICE_UNITS    = 3,
   parameter int CREDIT_W       = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input logic   clk,
   input logic   reset_n,
   vend_if.slave bus
);
   localparam int SLOT_W = $clog2(NUM_SLOTS);
   localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE_UNITS);
   localparam logic [CREDIT_W:0]   MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};

   if (NUM_SLOTS < 2 || NUM_SLOTS > 8 || PRICE_UNITS < 1 ||
       PRICE_UNITS > (2**CREDIT_W - 1) || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("vend_controller: parameter out of range");
   end

   vend_state_e         state_q;
   logic [CREDIT_W-1:0] credit_q;
   logic [SLOT_W-1:0]   rr_ptr_q;
   logic                disp_req_q;
   logic [SLOT_W-1:0]   disp_slot_q;
   logic                chg_req_q;
   logic                coin_reject_q;
   logic                fault_q;

   logic [NUM_SLOTS-1:0] eligible;
   logic [NUM_SLOTS-1:0] grant_onehot;
   logic [SLOT_W-1:0]    grant_idx;
   logic [SLOT_W-1:0]    next_ptr;
   logic                 can_vend;
   logic                 grant_ok;
   logic                 coin_seen;
   logic [CREDIT_W:0]    coin_sum;
   logic                 coin_bad;

   assign eligible = bus.sel_req & ~bus.slot_empty;

   vend_rr_arbiter #(.NUM_SLOTS(NUM_SLOTS)) u_arb (
      .req       (eligible),
      .ptr       (rr_ptr_q),
      .grant     (grant_onehot),
      .grant_idx (grant_idx)
   );

   assign can_vend  = (credit_q >= PRICE_C);
   assign grant_ok  = can_vend && (|grant_onehot) && !fault_q;
   assign next_ptr  = (grant_idx == SLOT_W'(NUM_SLOTS - 1)) ? '0 : grant_idx + 1'b1;
   assign coin_seen = (bus.coin != COIN_NONE);
   assign coin_sum  = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value(bus.coin));
   assign coin_bad  = (bus.coin == COIN_INVALID) || (coin_sum > MAX_CREDIT);

`ifdef VEND_TIMEOUT_EN
   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TIMER_W-1:0] timer_q;
`else
   assign fault_q = 1'b0;
`endif

   // Main sequencer. Grant outranks cancel, cancel outranks a coin; any coin that
   // cannot be credited this cycle is bounced with a one-cycle reject pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         credit_q      <= '0;
         rr_ptr_q      <= '0;
         disp_req_q    <= 1'b0;
         disp_slot_q   <= '0;
         chg_req_q     <= 1'b0;
         coin_reject_q <= 1'b0;
`ifdef VEND_TIMEOUT_EN
         fault_q       <= 1'b0;
         timer_q       <= '0;
`endif
      end else begin
         coin_reject_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (grant_ok) begin
                  disp_slot_q   <= grant_idx;
                  disp_req_q    <= 1'b1;
                  rr_ptr_q      <= next_ptr;
                  state_q       <= DISPENSE;
                  coin_reject_q <= coin_seen;
               end else if (bus.cancel && (credit_q != '0)) begin
                  chg_req_q     <= 1'b1;
                  state_q       <= CHANGE;
                  coin_reject_q <= coin_seen;
               end else if (coin_seen) begin
                  if (coin_bad) coin_reject_q <= 1'b1;
                  else          credit_q      <= coin_sum[CREDIT_W-1:0];
               end
            end
            DISPENSE: begin
               coin_reject_q <= coin_seen;
               if (bus.disp_ack) begin
                  credit_q   <= credit_q - PRICE_C;
                  disp_req_q <= 1'b0;
                  if (credit_q > PRICE_C) begin
                     chg_req_q <= 1'b1;
                     state_q   <= CHANGE;
                  end else begin
                     state_q   <= IDLE;
                  end
`ifdef VEND_TIMEOUT_EN
                  timer_q    <= '0;
               end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                  // Dispenser never answered: refund everything and lock out new sales.
                  timer_q    <= '0;
                  disp_req_q <= 1'b0;
                  fault_q    <= 1'b1;
                  chg_req_q  <= 1'b1;
                  state_q    <= CHANGE;
               end else begin
                  timer_q    <= timer_q + 1'b1;
`endif
               end
            end
            CHANGE: begin
               coin_reject_q <= coin_seen;
               if (credit_q == '0) begin
                  chg_req_q <= 1'b0;
                  state_q   <= IDLE;
               end else if (bus.chg_ack && chg_req_q) begin
                  credit_q <= credit_q - 1'b1;
                  if (credit_q == CREDIT_W'(1)) begin
                     chg_req_q <= 1'b0;
                     state_q   <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.credit      = credit_q;
   assign bus.can_vend    = can_vend;
   assign bus.disp_req    = disp_req_q;
   assign bus.disp_slot   = disp_slot_q;
   assign bus.chg_req     = chg_req_q;
   assign bus.coin_reject = coin_reject_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.fault       = fault_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed self-checking bench for vend_controller: a vector table for the basic
// credit/vend/change flow plus hand sequences for round-robin, refunds, timeout and reset.
module tb_vend_controller;

   localparam int NUM_SLOTS      = 4;
   localparam int PRICE_UNITS    = 3;
   localparam int CREDIT_W       = 4;
   localparam int TIMEOUT_CYCLES = 8;
   localparam int NUM_VECS       = 25;

   typedef struct {
      logic [1:0] coin;
      logic       cancel;
      logic [3:0] sel;
      logic [3:0] empty;
      logic       dack;
      logic       cack;
      logic [3:0] exp_credit;
      logic       exp_can_vend;
      logic       exp_disp_req;
      logic [1:0] exp_disp_slot;
      logic       exp_chg_req;
      logic       exp_reject;
      logic       exp_busy;
   } vec_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   checks  = 0;
   int   errors  = 0;
   vec_t vecs [NUM_VECS];

   always #5 clk = ~clk;

   vend_if #(.NUM_SLOTS(NUM_SLOTS), .CREDIT_W(CREDIT_W)) bus ();

   vend_controller #(
      .NUM_SLOTS      (NUM_SLOTS),
      .PRICE_UNITS    (PRICE_UNITS),
      .CREDIT_W       (CREDIT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic setInputs(input logic [1:0] coin, input logic cancel, input logic [3:0] sel,
                            input logic [3:0] empty, input logic dack, input logic cack);
      bus.coin       = coin;
      bus.cancel     = cancel;
      bus.sel_req    = sel;
      bus.slot_empty = empty;
      bus.disp_ack   = dack;
      bus.chg_ack    = cack;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v);
      setInputs(v.coin, v.cancel, v.sel, v.empty, v.dack, v.cack);
      tick();
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      checkValue($sformatf("vec%0d credit", idx),      32'(bus.credit),      32'(v.exp_credit));
      checkValue($sformatf("vec%0d can_vend", idx),    32'(bus.can_vend),    32'(v.exp_can_vend));
      checkValue($sformatf("vec%0d disp_req", idx),    32'(bus.disp_req),    32'(v.exp_disp_req));
      checkValue($sformatf("vec%0d disp_slot", idx),   32'(bus.disp_slot),   32'(v.exp_disp_slot));
      checkValue($sformatf("vec%0d chg_req", idx),     32'(bus.chg_req),     32'(v.exp_chg_req));
      checkValue($sformatf("vec%0d coin_reject", idx), 32'(bus.coin_reject), 32'(v.exp_reject));
      checkValue($sformatf("vec%0d busy", idx),        32'(bus.busy),        32'(v.exp_busy));
      checkValue($sformatf("vec%0d fault", idx),       32'(bus.fault),       32'd0);
   endtask

   task automatic checkCleared(input string tag);
      checkValue({tag, " credit"},      32'(bus.credit),      32'd0);
      checkValue({tag, " can_vend"},    32'(bus.can_vend),    32'd0);
      checkValue({tag, " disp_req"},    32'(bus.disp_req),    32'd0);
      checkValue({tag, " disp_slot"},   32'(bus.disp_slot),   32'd0);
      checkValue({tag, " chg_req"},     32'(bus.chg_req),     32'd0);
      checkValue({tag, " coin_reject"}, 32'(bus.coin_reject), 32'd0);
      checkValue({tag, " busy"},        32'(bus.busy),        32'd0);
      checkValue({tag, " fault"},       32'(bus.fault),       32'd0);
   endtask

   task automatic resetDut();
      setInputs(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkCleared("reset");
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      checkCleared("after reset");
   endtask

   // Return n nickels one ack pulse at a time, with an idle cycle between acks.
   task automatic drainChange(input int n, input logic coin_during);
      for (int i = n; i > 0; i--) begin
         checkValue("drain chg_req", 32'(bus.chg_req), 32'd1);
         checkValue("drain busy", 32'(bus.busy), 32'd1);
         setInputs((i == n && coin_during) ? 2'b01 : 2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
         tick();
         checkValue("drain credit", 32'(bus.credit), 32'(i - 1));
         if (i == n && coin_during) checkValue("change coin_reject", 32'(bus.coin_reject), 32'd1);
         setInputs(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
         tick();
         checkValue("drain credit hold", 32'(bus.credit), 32'(i - 1));
      end
      checkValue("drain chg_req low", 32'(bus.chg_req), 32'd0);
      checkValue("drain busy low", 32'(bus.busy), 32'd0);
   endtask

   // Dime + nickel makes exact price; grant is expected one cycle later.
   task automatic buyOnce(input logic [3:0] sel, input logic [3:0] empty, input int slot);
      setInputs(2'b10, 1'b0, sel, empty, 1'b0, 1'b0);
      tick();
      setInputs(2'b01, 1'b0, sel, empty, 1'b0, 1'b0);
      tick();
      checkValue("buy credit", 32'(bus.credit), 32'd3);
      checkValue("buy can_vend", 32'(bus.can_vend), 32'd1);
      checkValue("buy disp_req early", 32'(bus.disp_req), 32'd0);
      setInputs(2'b00, 1'b0, sel, empty, 1'b0, 1'b0);
      tick();
      checkValue("buy disp_req", 32'(bus.disp_req), 32'd1);
      checkValue("buy disp_slot", 32'(bus.disp_slot), 32'(slot));
   endtask

   task automatic finishVend();
      setInputs(2'b00, 1'b0, bus.sel_req, bus.slot_empty, 1'b1, 1'b0);
      tick();
      checkValue("vend done disp_req", 32'(bus.disp_req), 32'd0);
      checkValue("vend done credit", 32'(bus.credit), 32'd0);
      checkValue("vend done busy", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      //         coin  cncl sel      empty    dack cack  credit cv  dr  ds    cr  rej busy
      vecs[0]  = '{2'b01, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'd1,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{2'b01, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'd2,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{2'b01, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'd3,  1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{2'b00, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'd3,  1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1};
      vecs[4]  = '{2'b00, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{2'b10, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd2,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{2'b10, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'd4,  1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{2'b00, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'd4,  1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{2'b01, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd4,  1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1};
      vecs[9]  = '{2'b00, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'd1,  1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd1,  1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{2'b01, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'd1,  1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{2'b01, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'd2,  1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{2'b10, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd4,  1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{2'b10, 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b0, 4'd6,  1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{2'b10, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd8,  1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
      vecs[17] = '{2'b10, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd10, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
      vecs[18] = '{2'b10, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd12, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
      vecs[19] = '{2'b10, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd14, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
      vecs[20] = '{2'b10, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd14, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0};
      vecs[21] = '{2'b11, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd14, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0};
      vecs[22] = '{2'b01, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
      vecs[23] = '{2'b01, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0};
      vecs[24] = '{2'b01, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1};

      resetDut();

      for (int i = 0; i < NUM_VECS; i++) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i], i);
      end
      drainChange(15, 1'b1);

      // Cancel with a small credit refunds it nickel by nickel.
      setInputs(2'b10, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
      tick();
      checkValue("refund credit", 32'(bus.credit), 32'd2);
      setInputs(2'b00, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
      tick();
      checkValue("cancel chg_req", 32'(bus.chg_req), 32'd1);
      checkValue("cancel credit", 32'(bus.credit), 32'd2);
      drainChange(2, 1'b1);

      // Round robin from a fresh pointer, then with slot 1 sold out.
      resetDut();
      buyOnce(4'b1111, 4'b0000, 0); finishVend();
      buyOnce(4'b1111, 4'b0000, 1); finishVend();
      buyOnce(4'b1111, 4'b0000, 2); finishVend();
      buyOnce(4'b1111, 4'b0000, 3); finishVend();
      buyOnce(4'b1111, 4'b0010, 0); finishVend();
      buyOnce(4'b1111, 4'b0010, 2); finishVend();
      buyOnce(4'b1111, 4'b0010, 3); finishVend();
      buyOnce(4'b1111, 4'b0010, 0); finishVend();

      // Dispenser never acks: request must last exactly TIMEOUT_CYCLES when the timeout is built in.
      buyOnce(4'b0001, 4'b0000, 0);
      setInputs(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) tick();
      checkValue("stall disp_req", 32'(bus.disp_req), 32'd1);
      checkValue("stall fault", 32'(bus.fault), 32'd0);
      tick();
`ifdef VEND_TIMEOUT_EN
      checkValue("timeout disp_req", 32'(bus.disp_req), 32'd0);
      checkValue("timeout fault", 32'(bus.fault), 32'd1);
      checkValue("timeout credit", 32'(bus.credit), 32'd3);
      drainChange(3, 1'b0);
      checkValue("fault sticky", 32'(bus.fault), 32'd1);
      setInputs(2'b10, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0);
      tick();
      setInputs(2'b01, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0);
      tick();
      setInputs(2'b00, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0);
      tick();
      checkValue("fault credit", 32'(bus.credit), 32'd3);
      checkValue("fault no grant", 32'(bus.disp_req), 32'd0);
      checkValue("fault busy", 32'(bus.busy), 32'd0);
      setInputs(2'b00, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
      tick();
      drainChange(3, 1'b0);
      resetDut();
      buyOnce(4'b0001, 4'b0000, 0);
`else
      checkValue("no timeout disp_req", 32'(bus.disp_req), 32'd1);
      checkValue("no timeout fault", 32'(bus.fault), 32'd0);
      checkValue("no timeout credit", 32'(bus.credit), 32'd3);
`endif

      // Asynchronous reset in the middle of a dispense drops everything.
      setInputs(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
      tick();
      checkValue("pre-reset busy", 32'(bus.busy), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      checkCleared("mid-dispense reset");
      @(negedge clk);
      reset_n = 1'b1;
      setInputs(2'b01, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
      tick();
      checkValue("post-reset credit", 32'(bus.credit), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
